// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: takes words on a valid/ready handshake and shifts them out MSB first.
// Optional even-parity bit after the data bits is enabled by defining SER_PARITY_EN.
module serial_bit_feeder #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [1:0]       state_dbg
);

  // Handshake: a word transfers on a rising clk edge where in_valid and in_ready are both high;
  // in_ready is only high when idle or in the final clk of a frame, and nothing is buffered.

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef SER_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  shreg, shreg_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [CW-1:0]     div_cnt, div_cnt_n;
  logic              last_cycle;
  logic              accept;

`ifdef SER_PARITY_EN
  logic              par, par_n;
  assign last_cycle = (state == PARITY) && (div_cnt == '0);
  assign x_out      = ((state == SHIFT) && shreg[WIDTH-1]) || ((state == PARITY) && par);
`else
  assign last_cycle = (state == SHIFT) && (bit_cnt == '0) && (div_cnt == '0);
  assign x_out      = (state == SHIFT) && shreg[WIDTH-1];
`endif

  assign in_ready   = rst && ((state == IDLE) || last_cycle);
  assign accept     = in_valid && in_ready;
  assign x_valid    = (state != IDLE) && (div_cnt == DIV_LAST);
  assign busy       = (state != IDLE);
  assign frame_done = last_cycle;
  assign state_dbg  = state;

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
`ifdef SER_PARITY_EN
    par_n     = par;
`endif
    case (state)
      IDLE: ;
      SHIFT: begin
        if (div_cnt != '0) begin
          div_cnt_n = div_cnt - CW'(1);
        end else if (bit_cnt != '0) begin
          shreg_n   = {shreg[WIDTH-2:0], 1'b0};
          bit_cnt_n = bit_cnt - BW'(1);
          div_cnt_n = DIV_LAST;
        end else begin
`ifdef SER_PARITY_EN
          state_n   = PARITY;
          div_cnt_n = DIV_LAST;
`else
          state_n   = IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        if (div_cnt != '0) div_cnt_n = div_cnt - CW'(1);
        else               state_n   = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
    // A load at the end of a frame overrides the return to IDLE, giving gapless streaming.
    if (accept) begin
      state_n   = SHIFT;
      shreg_n   = in_data;
      bit_cnt_n = BIT_LAST;
      div_cnt_n = DIV_LAST;
`ifdef SER_PARITY_EN
      par_n     = ^in_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
`ifdef SER_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      div_cnt <= div_cnt_n;
`ifdef SER_PARITY_EN
      par     <= par_n;
`endif
    end
  end

endmodule
